// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI responder.
package adc_spi_pkg;

  localparam int DEFAULT_SAMPLE_W    = 16;
  localparam int DEFAULT_CONV_CYCLES = 35;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY,
    SHIFT
  } state_t;

  // Bit positions inside the sticky error vector.
  localparam int ERR_SHORT  = 0;
  localparam int ERR_EXCESS = 1;
  localparam int ERR_ABORT  = 2;

endpackage

// File: rtl/spi_edge_detect.sv
// Two-stage input register for an asynchronous SPI pin with rise/fall strobes.
module spi_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic level
);

  logic q;
  logic qq;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q  <= 1'b0;
      qq <= 1'b0;
    end else begin
      q  <= d;
      qq <= q;
    end
  end

  assign rise  = q & ~qq;
  assign fall  = ~q & qq;
  assign level = q;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates an external SPI ADC: cnv rise latches a sample, the frame shifts it
// out MSB-first on MISO, and initiator protocol violations are kept sticky.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int CONV_CYCLES = DEFAULT_CONV_CYCLES
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                err_clear_i,
  input  logic                spi_cnv_i,
  input  logic                spi_clk_i,
  input  logic                spi_mosi_i,
  output logic                spi_miso_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [2:0]          err_o
);

  localparam int TIMER_W  = $clog2(CONV_CYCLES + 1);
  localparam int BITCNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [TIMER_W-1:0]  CONV_LAST = TIMER_W'(CONV_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  CONV_DONE = TIMER_W'(CONV_CYCLES);
  localparam logic [BITCNT_W-1:0] BIT_LAST  = BITCNT_W'(SAMPLE_W - 1);

  logic cnv_rise, cnv_fall, cnv_level;
  logic sclk_rise, sclk_fall, sclk_level;
  logic mosi_rise, mosi_fall, mosi_level;

  spi_edge_detect u_cnv (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (spi_cnv_i),
    .rise    (cnv_rise),
    .fall    (cnv_fall),
    .level   (cnv_level)
  );

  spi_edge_detect u_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (spi_clk_i),
    .rise    (sclk_rise),
    .fall    (sclk_fall),
    .level   (sclk_level)
  );

  spi_edge_detect u_mosi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (spi_mosi_i),
    .rise    (mosi_rise),
    .fall    (mosi_fall),
    .level   (mosi_level)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

  state_t                state;
  logic [SAMPLE_W-1:0]   shreg;
  logic [TIMER_W-1:0]    timer;
  logic [BITCNT_W-1:0]   bitcnt;
  logic                  frame_hit;
  logic [2:0]            err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      shreg     <= '0;
      timer     <= '0;
      bitcnt    <= '0;
      frame_hit <= 1'b0;
      err       <= '0;
    end else begin
      frame_hit <= 1'b0;
      // NOTE: error bits set further down are later non-blocking writes, so a
      // new error in the same cycle as err_clear_i survives the clear.
      if (err_clear_i) err <= '0;

      unique case (state)
        IDLE: begin
          if (cnv_rise) begin
            state <= CONVERT;
            shreg <= sample_i;
            timer <= '0;
          end else if (sclk_rise && !cnv_level) begin
            // Only rises count: the fall after the last bit lands here legally.
            err[ERR_EXCESS] <= 1'b1;
          end
        end

        CONVERT: begin
          if (cnv_fall) begin
            state  <= SHIFT;
            bitcnt <= '0;
            if (timer != CONV_LAST) err[ERR_SHORT] <= 1'b1;
          end else if (timer == CONV_LAST) begin
            state <= READY;
            timer <= CONV_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        READY: begin
          if (cnv_fall) begin
            state  <= SHIFT;
            bitcnt <= '0;
          end
        end

        SHIFT: begin
          if (cnv_rise) begin
            err[ERR_ABORT] <= 1'b1;
            state          <= CONVERT;
            shreg          <= sample_i;
            timer          <= '0;
          end else if (sclk_rise) begin
            bitcnt <= bitcnt + 1'b1;
            if (!mosi_level) err[ERR_SHORT] <= 1'b1;
            if (bitcnt == BIT_LAST) begin
              frame_hit <= 1'b1;
              state     <= IDLE;
            end
          end else if (sclk_fall) begin
            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Output register: third stage of the pin-to-pin latency.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      spi_miso_o   <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= '0;
    end else begin
      spi_miso_o   <= (state == SHIFT) && shreg[SAMPLE_W-1];
      busy_o       <= (state == CONVERT);
      frame_done_o <= frame_hit;
      err_o        <= err;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder acting as an SPI initiator.
module tb_adc_spi_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] sample_i;
  logic        err_clear_i;
  logic        spi_cnv_i;
  logic        spi_clk_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [2:0]  err_o;

  int n_pass  = 0;
  int n_total = 0;
  int busy_cnt = 0;
  int fd_cnt   = 0;

  adc_spi_responder #(.SAMPLE_W(16), .CONV_CYCLES(35)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sample_i     (sample_i),
    .err_clear_i  (err_clear_i),
    .spi_cnv_i    (spi_cnv_i),
    .spi_clk_i    (spi_clk_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  always #10 clk_i = ~clk_i;

  // Every sample point is 1 ns after the rising edge; outputs are tallied here.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
      if (busy_o === 1'b1) busy_cnt++;
      if (frame_done_o === 1'b1) fd_cnt++;
    end
  endtask

  // cnv high for conv_ticks, then nbits SCLKs of 4 high / 4 low; MISO is
  // captured at each rise. mosi_low_bit < 0 keeps MOSI high throughout.
  task automatic spi_frame(input int conv_ticks, input int nbits, input int mosi_low_bit,
                           output logic [15:0] data, output logic [1:0] extra);
    data  = '0;
    extra = '0;
    spi_cnv_i = 1'b1;
    tick(conv_ticks);
    spi_cnv_i = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) data = {data[14:0], spi_miso_o};
      else if (i < 18) extra[i-16] = spi_miso_o;
      spi_clk_i = 1'b1;
      if (i == mosi_low_bit) spi_mosi_i = 1'b0;
      tick(4);
      spi_clk_i  = 1'b0;
      spi_mosi_i = 1'b1;
      tick(4);
    end
  endtask

  task automatic clear_errors();
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(3);
    n_total++; if (spi_miso_o !== 1'b0) $display("FAIL reset_miso: got %b expected 0", spi_miso_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_total++; if (frame_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done_o); else n_pass++;
    n_total++; if (err_o !== 3'b000) $display("FAIL reset_err: got %b expected 000", err_o); else n_pass++;
    reset_i = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    logic [15:0] d;
    logic [1:0]  x;
    int b0, f0;
    sample_i = 16'hA5C3;
    b0 = busy_cnt; f0 = fd_cnt;
    spi_frame(40, 16, -1, d, x);
    n_total++; if (d !== 16'hA5C3) $display("FAIL basic_data: got %h expected a5c3", d); else n_pass++;
    n_total++; if (fd_cnt - f0 != 1) $display("FAIL basic_done: got %0d pulses expected 1", fd_cnt - f0); else n_pass++;
    n_total++; if (busy_cnt - b0 != 35) $display("FAIL basic_busy: got %0d cycles expected 35", busy_cnt - b0); else n_pass++;
    n_total++; if (err_o !== 3'b000) $display("FAIL basic_err: got %b expected 000", err_o); else n_pass++;
    n_total++; if (spi_miso_o !== 1'b0) $display("FAIL basic_idle_miso: got %b expected 0", spi_miso_o); else n_pass++;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [1:0]  x;
    int b0;
    sample_i = 16'h8000;
    b0 = busy_cnt;
    spi_frame(40, 16, -1, d, x);
    n_total++; if (d !== 16'h8000) $display("FAIL b2b_data0: got %h expected 8000", d); else n_pass++;
    n_total++; if (busy_cnt - b0 != 35) $display("FAIL b2b_busy0: got %0d cycles expected 35", busy_cnt - b0); else n_pass++;
    sample_i = 16'h7FFF;
    b0 = busy_cnt;
    spi_frame(40, 16, -1, d, x);
    n_total++; if (d !== 16'h7FFF) $display("FAIL b2b_data1: got %h expected 7fff", d); else n_pass++;
    n_total++; if (busy_cnt - b0 != 35) $display("FAIL b2b_busy1: got %0d cycles expected 35", busy_cnt - b0); else n_pass++;
    n_total++; if (err_o !== 3'b000) $display("FAIL b2b_err: got %b expected 000", err_o); else n_pass++;
    tick(2);
  endtask

  task automatic test_short_conv();
    logic [15:0] d;
    logic [1:0]  x;
    int f0;
    sample_i = 16'hA5C3;
    f0 = fd_cnt;
    spi_frame(10, 16, -1, d, x);
    n_total++; if (d !== 16'hA5C3) $display("FAIL short_data: got %h expected a5c3", d); else n_pass++;
    n_total++; if (err_o !== 3'b001) $display("FAIL short_err: got %b expected 001", err_o); else n_pass++;
    n_total++; if (fd_cnt - f0 != 1) $display("FAIL short_done: got %0d pulses expected 1", fd_cnt - f0); else n_pass++;
    clear_errors();
    n_total++; if (err_o !== 3'b000) $display("FAIL short_clear: got %b expected 000", err_o); else n_pass++;
  endtask

  task automatic test_abort();
    logic [15:0] d;
    logic [1:0]  x;
    int f0;
    sample_i = 16'h5A3C;
    f0 = fd_cnt;
    spi_frame(40, 7, -1, d, x);
    n_total++; if (d !== 16'h005A >> 1) $display("FAIL abort_partial: got %h expected 002d", d); else n_pass++;
    n_total++; if (fd_cnt - f0 != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", fd_cnt - f0); else n_pass++;
    sample_i = 16'hC0DE;
    f0 = fd_cnt;
    spi_frame(40, 16, -1, d, x);
    n_total++; if (d !== 16'hC0DE) $display("FAIL abort_relatch: got %h expected c0de", d); else n_pass++;
    n_total++; if (err_o !== 3'b100) $display("FAIL abort_err: got %b expected 100", err_o); else n_pass++;
    n_total++; if (fd_cnt - f0 != 1) $display("FAIL abort_done: got %0d pulses expected 1", fd_cnt - f0); else n_pass++;
    clear_errors();
  endtask

  task automatic test_excess_clk();
    logic [15:0] d;
    logic [1:0]  x;
    int f0;
    sample_i = 16'h3C5B;
    f0 = fd_cnt;
    spi_frame(40, 18, -1, d, x);
    n_total++; if (d !== 16'h3C5B) $display("FAIL excess_data: got %h expected 3c5b", d); else n_pass++;
    n_total++; if (x !== 2'b00) $display("FAIL excess_miso: got %b expected 00", x); else n_pass++;
    n_total++; if (fd_cnt - f0 != 1) $display("FAIL excess_done: got %0d pulses expected 1", fd_cnt - f0); else n_pass++;
    n_total++; if (err_o !== 3'b010) $display("FAIL excess_err: got %b expected 010", err_o); else n_pass++;
    clear_errors();
    n_total++; if (err_o !== 3'b000) $display("FAIL excess_clear: got %b expected 000", err_o); else n_pass++;
  endtask

  task automatic test_mosi_low();
    logic [15:0] d;
    logic [1:0]  x;
    sample_i = 16'h0F0F;
    spi_frame(40, 16, 3, d, x);
    n_total++; if (d !== 16'h0F0F) $display("FAIL mosi_data: got %h expected 0f0f", d); else n_pass++;
    n_total++; if (err_o !== 3'b001) $display("FAIL mosi_err: got %b expected 001", err_o); else n_pass++;
    clear_errors();
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    logic [1:0]  x;
    int f0;
    sample_i = 16'hFFFF;
    spi_frame(40, 5, -1, d, x);
    n_total++; if (spi_miso_o !== 1'b1) $display("FAIL midreset_pre_miso: got %b expected 1", spi_miso_o); else n_pass++;
    reset_i = 1'b1;
    tick();
    n_total++; if (spi_miso_o !== 1'b0) $display("FAIL midreset_miso: got %b expected 0", spi_miso_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy_o); else n_pass++;
    n_total++; if (frame_done_o !== 1'b0) $display("FAIL midreset_done: got %b expected 0", frame_done_o); else n_pass++;
    n_total++; if (err_o !== 3'b000) $display("FAIL midreset_err: got %b expected 000", err_o); else n_pass++;
    reset_i = 1'b0;
    tick(2);
    sample_i = 16'h1234;
    f0 = fd_cnt;
    spi_frame(40, 16, -1, d, x);
    n_total++; if (d !== 16'h1234) $display("FAIL midreset_data: got %h expected 1234", d); else n_pass++;
    n_total++; if (fd_cnt - f0 != 1) $display("FAIL midreset_done2: got %0d pulses expected 1", fd_cnt - f0); else n_pass++;
    n_total++; if (err_o !== 3'b000) $display("FAIL midreset_err2: got %b expected 000", err_o); else n_pass++;
  endtask

  initial begin
    reset_i     = 1'b1;
    sample_i    = '0;
    err_clear_i = 1'b0;
    spi_cnv_i   = 1'b0;
    spi_clk_i   = 1'b0;
    spi_mosi_i  = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_conv();
    test_abort();
    test_excess_clk();
    test_mosi_low();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
